// File: rtl/dram_pkg.sv
// Shared widths, state encoding and port identifiers for the two-port DRAM arbiter.
package dram_pkg;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/dram_arbiter_if.sv
// Requester ports A/B, the DRAM controller request/response and the error flag.
interface dram_arbiter_if;
    logic                       a_valid;
    logic [dram_pkg::ADDR_W-1:0] a_addr;
    logic                       a_wmask;
    logic [dram_pkg::LINE_W-1:0] a_wdata;
    logic                       a_ready;
    logic [dram_pkg::LINE_W-1:0] a_rdata;

    logic                       b_valid;
    logic [dram_pkg::ADDR_W-1:0] b_addr;
    logic                       b_wmask;
    logic [dram_pkg::LINE_W-1:0] b_wdata;
    logic                       b_ready;
    logic [dram_pkg::LINE_W-1:0] b_rdata;

    logic                       mem_valid;
    logic [dram_pkg::ADDR_W-1:0] mem_addr;
    logic                       mem_wmask;
    logic [dram_pkg::LINE_W-1:0] mem_wdata;
    logic                       mem_ready;
    logic [dram_pkg::LINE_W-1:0] mem_rdata;

    logic                       err;

    modport slave (
        input  a_valid, a_addr, a_wmask, a_wdata,
        input  b_valid, b_addr, b_wmask, b_wdata,
        input  mem_ready, mem_rdata,
        output a_ready, a_rdata, b_ready, b_rdata,
        output mem_valid, mem_addr, mem_wmask, mem_wdata,
        output err
    );

    modport master (
        output a_valid, a_addr, a_wmask, a_wdata,
        output b_valid, b_addr, b_wmask, b_wdata,
        output mem_ready, mem_rdata,
        input  a_ready, a_rdata, b_ready, b_rdata,
        input  mem_valid, mem_addr, mem_wmask, mem_wdata,
        input  err
    );
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that did not win last time wins.
module rr_pick2
    import dram_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);
    always_comb begin
        any   = |valid;
        grant = PORT_A;
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end else if (valid[PORT_B]) begin
            grant = PORT_B;
        end
    end
endmodule

// File: rtl/dram_arbiter.sv
// Two-port arbiter in front of a single-outstanding DRAM controller, with a sticky BUSY timeout flag.
module dram_arbiter
    import dram_pkg::*;
#(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          rst,
    dram_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t              state_q, state_d;
    // The granted port doubles as last_grant: both are written on the same edge.
    logic                grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wmask_q, wmask_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic                a_ready_q, a_ready_d;
    logic                b_ready_q, b_ready_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic                pick_grant;
    logic                pick_any;

    rr_pick2 u_pick (
        .valid      ({bus.b_valid, bus.a_valid}),
        .last_grant (grant_q),
        .grant      (pick_grant),
        .any        (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= PORT_B;
            addr_q    <= '0;
            wmask_q   <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            a_ready_q <= 1'b0;
            b_ready_q <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wmask_q   <= wmask_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            a_ready_q <= a_ready_d;
            b_ready_q <= b_ready_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wmask_d   = wmask_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        a_ready_d = 1'b0;
        b_ready_d = 1'b0;
        cnt_d     = cnt_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    grant_d = pick_grant;
                    addr_d  = (pick_grant == PORT_B) ? bus.b_addr  : bus.a_addr;
                    wmask_d = (pick_grant == PORT_B) ? bus.b_wmask : bus.a_wmask;
                    wdata_d = (pick_grant == PORT_B) ? bus.b_wdata : bus.a_wdata;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // The counter equals the number of completed BUSY cycles, so err rises in BUSY cycle TIMEOUT.
                cnt_d = sat_inc(cnt_q);
                if (cnt_d == TIMEOUT_CNT) begin
                    err_d = 1'b1;
                end
                if (bus.mem_ready) begin
                    state_d   = DONE;
                    rdata_d   = bus.mem_rdata;
                    a_ready_d = (grant_q == PORT_A);
                    b_ready_d = (grant_q == PORT_B);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Drop valid in the controller's ready cycle so it never sees a second request.
    assign bus.mem_valid = (state_q == BUSY) && !bus.mem_ready;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wmask = wmask_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.a_ready   = a_ready_q;
    assign bus.b_ready   = b_ready_q;
    assign bus.a_rdata   = rdata_q;
    assign bus.b_rdata   = rdata_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios plus randomized rounds against a round-robin model.
module tb_dram_arbiter;
    import dram_pkg::*;

    localparam int unsigned TB_TIMEOUT = 8;

    logic clk;
    logic rst;
    int   checks = 0;
    int   passed = 0;
    int   rises = 0;
    int   both_ready_seen = 0;
    logic mv_prev = 1'b0;

    dram_arbiter_if bus ();

    dram_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream request count (rising edges of mem_valid) and the mutual-exclusion watch on the ready pulses.
    always @(negedge clk) begin
        if (bus.mem_valid && !mv_prev) rises++;
        mv_prev = bus.mem_valid;
        if (bus.a_ready && bus.b_ready) both_ready_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_wmask = 1'b0; bus.a_wdata = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_wmask = 1'b0; bus.b_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Pulse mem_ready for one cycle; returns in the DONE cycle.
    task automatic complete(input logic [LINE_W-1:0] rd);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
        tick();
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.a_ready !== 1'b0) $display("FAIL reset_a_ready got=%b want=0", bus.a_ready); else passed++;
        checks++; if (bus.b_ready !== 1'b0) $display("FAIL reset_b_ready got=%b want=0", bus.b_ready); else passed++;
        checks++; if (bus.err !== 1'b0) $display("FAIL reset_err got=%b want=0", bus.err); else passed++;
        checks++; if (bus.mem_valid !== 1'b0) $display("FAIL reset_mem_valid got=%b want=0", bus.mem_valid); else passed++;
        checks++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr got=%h want=0", bus.mem_addr); else passed++;
        checks++; if (bus.mem_wmask !== 1'b0) $display("FAIL reset_mem_wmask got=%b want=0", bus.mem_wmask); else passed++;
        checks++; if (bus.mem_wdata !== 128'h0) $display("FAIL reset_mem_wdata got=%h want=0", bus.mem_wdata); else passed++;
        checks++; if (bus.a_rdata !== 128'h0) $display("FAIL reset_rdata got=%h want=0", bus.a_rdata); else passed++;
        checks++; if (dut.state_q !== IDLE) $display("FAIL reset_state got=%0d want=%0d", dut.state_q, IDLE); else passed++;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.mem_valid !== 1'b0) $display("FAIL idle_no_valid got=%b want=0", bus.mem_valid); else passed++;
    endtask

    task automatic test_single_read();
        logic [LINE_W-1:0] rd;
        rd = {32'hDEAD_0000, 32'h1111_2222, 32'h3333_4444, 32'h0000_BEEF};
        bus.a_valid = 1'b1; bus.a_addr = 32'h0000_1000; bus.a_wmask = 1'b0;
        tick();
        checks++; if (bus.mem_valid !== 1'b1) $display("FAIL read_mem_valid got=%b want=1", bus.mem_valid); else passed++;
        checks++; if (bus.mem_addr !== 32'h0000_1000) $display("FAIL read_mem_addr got=%h want=00001000", bus.mem_addr); else passed++;
        checks++; if (bus.mem_wmask !== 1'b0) $display("FAIL read_mem_wmask got=%b want=0", bus.mem_wmask); else passed++;
        repeat (11) tick();
        bus.mem_ready = 1'b1; bus.mem_rdata = rd;
        #1;
        checks++; if (bus.mem_valid !== 1'b0) $display("FAIL read_valid_in_ready_cycle got=%b want=0", bus.mem_valid); else passed++;
        tick();
        bus.mem_ready = 1'b0;
        checks++; if (bus.a_ready !== 1'b1) $display("FAIL read_a_ready got=%b want=1", bus.a_ready); else passed++;
        checks++; if (bus.a_rdata !== rd) $display("FAIL read_a_rdata got=%h want=%h", bus.a_rdata, rd); else passed++;
        checks++; if (bus.b_ready !== 1'b0) $display("FAIL read_b_ready got=%b want=0", bus.b_ready); else passed++;
        bus.a_valid = 1'b0;
        tick();
        checks++; if (bus.a_ready !== 1'b0) $display("FAIL read_a_ready_pulse got=%b want=0", bus.a_ready); else passed++;
        tick();
        checks++; if (bus.mem_valid !== 1'b0) $display("FAIL read_no_regrant got=%b want=0", bus.mem_valid); else passed++;
        $display("txn single_read: port A addr=00001000 rdata=%h", rd);
    endtask

    task automatic test_contention();
        do_reset();
        for (int pair = 0; pair < 2; pair++) begin
            logic [ADDR_W-1:0] aa, ba;
            aa = 32'h100 + 32'(pair * 32'h200);
            ba = 32'h200 + 32'(pair * 32'h200);
            bus.a_valid = 1'b1; bus.a_addr = aa; bus.a_wmask = 1'b0;
            bus.b_valid = 1'b1; bus.b_addr = ba; bus.b_wmask = 1'b0;
            tick();
            checks++; if (bus.mem_addr !== aa) $display("FAIL contention_first pair=%0d got=%h want=%h", pair, bus.mem_addr, aa); else passed++;
            tick();
            complete(128'hA);
            checks++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) $display("FAIL contention_a_ready pair=%0d got=%b%b want=10", pair, bus.a_ready, bus.b_ready); else passed++;
            bus.a_valid = 1'b0;
            tick();
            tick();
            checks++; if (bus.mem_addr !== ba) $display("FAIL contention_second pair=%0d got=%h want=%h", pair, bus.mem_addr, ba); else passed++;
            tick();
            complete(128'hB);
            checks++; if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) $display("FAIL contention_b_ready pair=%0d got=%b%b want=01", pair, bus.a_ready, bus.b_ready); else passed++;
            checks++; if (bus.b_rdata !== 128'hB) $display("FAIL contention_b_rdata pair=%0d got=%h want=b", pair, bus.b_rdata); else passed++;
            bus.b_valid = 1'b0;
            tick();
            $display("txn contention pair %0d: A addr=%h then B addr=%h", pair, aa, ba);
        end
    endtask

    task automatic test_write();
        logic [LINE_W-1:0] wd;
        wd = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        bus.b_valid = 1'b1; bus.b_addr = 32'h40; bus.b_wmask = 1'b1; bus.b_wdata = wd;
        tick();
        // Requester fields change after the grant; the latched request must not follow.
        bus.b_addr = 32'hFFFF_FFF0; bus.b_wmask = 1'b0; bus.b_wdata = ~wd;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.mem_wdata !== wd || bus.mem_wmask !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_valid !== 1'b1)
                $display("FAIL write_stable k=%0d got=%h/%b/%h/%b want=%h/1/00000040/1", k, bus.mem_wdata, bus.mem_wmask, bus.mem_addr, bus.mem_valid, wd);
            else passed++;
            tick();
        end
        complete(128'h5);
        checks++; if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) $display("FAIL write_b_ready got=%b%b want=01", bus.a_ready, bus.b_ready); else passed++;
        bus.b_valid = 1'b0;
        tick();
        checks++; if (bus.b_ready !== 1'b0) $display("FAIL write_b_ready_pulse got=%b want=0", bus.b_ready); else passed++;
        $display("txn write: port B addr=00000040 wdata=%h", wd);
    endtask

    task automatic test_reset_mid_busy();
        bus.a_valid = 1'b1; bus.a_addr = 32'h777; bus.a_wmask = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_valid !== 1'b0) $display("FAIL rstmid_mem_valid got=%b want=0", bus.mem_valid); else passed++;
        checks++; if (bus.mem_addr !== 32'h0) $display("FAIL rstmid_mem_addr got=%h want=0", bus.mem_addr); else passed++;
        bus.a_valid = 1'b0;
        tick();
        rst = 1'b0;
        complete(128'hCAFE_F00D);
        checks++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) $display("FAIL rstmid_stray_ready got=%b%b want=00", bus.a_ready, bus.b_ready); else passed++;
        checks++; if (dut.state_q !== IDLE) $display("FAIL rstmid_state got=%0d want=%0d", dut.state_q, IDLE); else passed++;
        checks++; if (bus.a_rdata !== 128'h0) $display("FAIL rstmid_rdata got=%h want=0", bus.a_rdata); else passed++;
        $display("txn reset_mid_busy: port A addr=00000777 abandoned");
    endtask

    task automatic test_timeout();
        do_reset();
        checks++; if (bus.err !== 1'b0) $display("FAIL timeout_err_init got=%b want=0", bus.err); else passed++;
        bus.a_valid = 1'b1; bus.a_addr = 32'h900; bus.a_wmask = 1'b0;
        tick();
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (bus.err !== (k >= int'(TB_TIMEOUT))) $display("FAIL timeout_err busy_cycle=%0d got=%b want=%b", k, bus.err, (k >= int'(TB_TIMEOUT)));
            else passed++;
            tick();
        end
        complete(128'h77);
        checks++; if (bus.a_ready !== 1'b1) $display("FAIL timeout_completion got=%b want=1", bus.a_ready); else passed++;
        bus.a_valid = 1'b0;
        tick();
        checks++; if (bus.err !== 1'b1 || bus.a_ready !== 1'b0) $display("FAIL timeout_sticky got=err %b ready %b want=err 1 ready 0", bus.err, bus.a_ready); else passed++;
        $display("txn timeout: port A addr=00000900 completed after 20 busy cycles");
    endtask

    task automatic test_random_rounds();
        logic [ADDR_W-1:0] ad [2];
        logic              wm [2];
        logic [LINE_W-1:0] wd [2];
        logic [LINE_W-1:0] rd;
        logic [1:0]        sel, pending;
        logic              last_b, exp_p, got_rdy, other_rdy;
        logic [LINE_W-1:0] got_rd;
        int                rise0, issued, waited;
        do_reset();
        last_b = PORT_B;
        rise0  = rises;
        issued = 0;
        for (int r = 0; r < 30; r++) begin
            sel = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                ad[p] = $urandom();
                wm[p] = 1'($urandom_range(0, 1));
                wd[p] = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            bus.a_valid = sel[0]; bus.a_addr = ad[0]; bus.a_wmask = wm[0]; bus.a_wdata = wd[0];
            bus.b_valid = sel[1]; bus.b_addr = ad[1]; bus.b_wmask = wm[1]; bus.b_wdata = wd[1];
            pending = sel;
            while (pending != 2'b00) begin
                // Sole requester wins; on a tie the port not served last wins.
                exp_p = (pending == 2'b11) ? ~last_b : pending[1];
                waited = 0;
                do begin
                    tick();
                    waited++;
                end while (!bus.mem_valid && waited < 10);
                checks++;
                if (!bus.mem_valid) begin
                    $display("FAIL rand_wait_request round=%0d got=no mem_valid want=mem_valid within 10 cycles", r);
                    return;
                end
                passed++;
                checks++;
                if (bus.mem_addr !== ad[exp_p] || bus.mem_wmask !== wm[exp_p] || bus.mem_wdata !== wd[exp_p])
                    $display("FAIL rand_request round=%0d got=%h/%b want=%h/%b (port %0d)", r, bus.mem_addr, bus.mem_wmask, ad[exp_p], wm[exp_p], exp_p);
                else passed++;
                if ($urandom_range(0, 1) == 1) begin
                    if (exp_p == PORT_B) bus.b_valid = 1'b0; else bus.a_valid = 1'b0;
                end
                repeat ($urandom_range(1, 4)) tick();
                rd = {$urandom(), $urandom(), $urandom(), $urandom()};
                complete(rd);
                got_rdy   = (exp_p == PORT_B) ? bus.b_ready : bus.a_ready;
                other_rdy = (exp_p == PORT_B) ? bus.a_ready : bus.b_ready;
                got_rd    = (exp_p == PORT_B) ? bus.b_rdata : bus.a_rdata;
                checks++;
                if (got_rdy !== 1'b1 || other_rdy !== 1'b0 || got_rd !== rd)
                    $display("FAIL rand_response round=%0d port=%0d got=rdy %b other %b rdata %h want=rdy 1 other 0 rdata %h", r, exp_p, got_rdy, other_rdy, got_rd, rd);
                else passed++;
                if (exp_p == PORT_B) bus.b_valid = 1'b0; else bus.a_valid = 1'b0;
                last_b = exp_p;
                pending[exp_p] = 1'b0;
                issued++;
                $display("txn rand %0d: port %s %s addr=%h rdata=%h", issued, exp_p ? "B" : "A", wm[exp_p] ? "write" : "read", ad[exp_p], rd);
                tick();
                checks++;
                if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) $display("FAIL rand_ready_pulse round=%0d got=%b%b want=00", r, bus.a_ready, bus.b_ready);
                else passed++;
            end
        end
        tick();
        checks++; if (bus.mem_valid !== 1'b0) $display("FAIL rand_idle_after got=%b want=0", bus.mem_valid); else passed++;
        checks++; if (rises - rise0 != issued) $display("FAIL rand_request_count got=%0d want=%0d", rises - rise0, issued); else passed++;
        checks++; if (both_ready_seen != 0) $display("FAIL both_ready_cycles got=%0d want=0", both_ready_seen); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_reset_mid_busy();
        test_timeout();
        test_random_rounds();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 65535: BUSY-cycle limit before err is raised; range 1..65535.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a_valid / b_valid  input  1 each  request from port A (instruction fetch) / port B (data); held high until that port's ready.
REQ-005 a_addr / b_addr  input  32  byte address.
REQ-006 a_wmask / b_wmask  input  1  1 = write, 0 = read.
REQ-007 a_wdata / b_wdata  input  128  write line.
REQ-008 a_ready / b_ready  output  1  one-cycle completion pulse per port.
REQ-009 a_rdata / b_rdata  output  128  read line; both driven from one shared response register.
REQ-010 mem_valid  output  1  request to the DRAM controller.
REQ-011 mem_addr, mem_wmask, mem_wdata  output  32/1/128  request fields to the controller.
REQ-012 mem_ready  input  1  one-cycle completion pulse from the controller.
REQ-013 mem_rdata  input  128  controller read line; valid only in the mem_ready cycle.
REQ-014 err  output  1  sticky timeout flag.

Function
REQ-015 States: IDLE, BUSY, DONE; 2-bit encoding.
REQ-016 IDLE, no valid: remain in IDLE.
REQ-017 IDLE, exactly one valid: grant that port.
REQ-018 IDLE, both valid: grant the port that is not last_grant; last_grant resets to B, so A wins first.
REQ-019 Grant edge: latch addr/wmask/wdata into the mem_* registers, record grant and last_grant, clear the BUSY counter, go to BUSY.
REQ-020 mem_* fields stay stable from grant until exit from BUSY.
REQ-021 mem_valid = (state==BUSY) AND NOT mem_ready, combinational, so the controller never sees valid in the cycle after its ready pulse.
REQ-022 BUSY, mem_ready=1: latch mem_rdata into the response register; go to DONE.
REQ-023 Writes also latch mem_rdata; content is don't-care.
REQ-024 DONE: assert the granted port's ready (registered) for exactly this cycle; next state IDLE unconditionally.
REQ-025 A requester that drops valid on the edge where it samples ready is never re-granted for the same transaction.
REQ-026 Latency: valid seen at edge g gives mem_valid high in cycle g+1; mem_ready in cycle m gives port ready in cycle m+1.
REQ-027 mem_ready while IDLE or DONE is ignored: no state change, no response-register update.
REQ-028 A port's valid dropping during BUSY does not abort the transaction; completion still pulses that port's ready.
REQ-029 BUSY counter: 16-bit, saturating.
REQ-030 When the BUSY counter reaches TIMEOUT, set err; it stays set until rst. The transaction keeps waiting.
REQ-031 a_ready and b_ready are never high in the same cycle.
REQ-032 At most one transaction is outstanding downstream.

Reset
REQ-033 rst forces immediately, without waiting for clk: state=IDLE, last_grant=B, mem_addr=0, mem_wmask=0, mem_wdata=0, response register=0, a_ready=b_ready=0, err=0, BUSY counter=0.
REQ-034 rst asserted mid-BUSY abandons the transaction; a later mem_ready from the controller is ignored per REQ-027.

Structure
REQ-035 Package dram_pkg holds: ADDR_W=32, LINE_W=128, state encoding, port-ID constants PORT_A/PORT_B.
REQ-036 One sub-module, rr_pick2: combinational two-way round-robin picker with inputs valid[1:0] and last_grant, outputs grant and any.
REQ-037 Target implementation size: 120-250 RTL lines.

Verification
REQ-038 Single read: A read addr=0x0000_1000, mem_ready 12 cycles later with mem_rdata=0xDEAD..BEEF -> mem_addr=0x1000, mem_wmask=0; a_ready pulses one cycle with a_rdata=0xDEAD..BEEF; b_ready stays 0.
REQ-039 Contention: A and B valid on the same edge after reset -> A granted first, then B; a second simultaneous pair -> A again, since last_grant=B after the first pair.
REQ-040 Back-to-back: controller mem_ready pulse while mem_valid is observed -> mem_valid=0 in that cycle; exactly one controller transaction per request, checked by counting mem_valid rising edges.
REQ-041 Write: B write addr=0x40, wdata=0x0123..CDEF -> mem_wdata and mem_wmask=1 held stable through BUSY; b_ready pulses one cycle.
REQ-042 Reset mid-BUSY: rst asserted, then a stray mem_ready after release -> no port ready, state IDLE, response register 0.
REQ-043 Timeout: TIMEOUT=8, mem_ready withheld 20 cycles -> err=1 from BUSY cycle 8 and stays 1; completion at cycle 20 still pulses ready.
